reg_file_sb: RTL and testbench



---
 rtl/reg_file_pkg.sv | 14 +
 rtl/reg_file_sb_scoreboard.sv | 59 +++++
 rtl/reg_file_sb.sv | 97 +++++++++
 tb/tb_reg_file_sb.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/reg_file_pkg.sv
// Shared constants and types for the scoreboarded register file.
// Optional write-through bypass is enabled by defining REGFILE_BYPASS_EN.
package reg_file_pkg;

    localparam int unsigned DATA_W_DEF = 16;
    localparam int unsigned ADDR_W_DEF = 3;

    // Register 0 reads as zero and ignores writes and issues.
    localparam int unsigned ZERO_REG = 0;

    typedef logic [ADDR_W_DEF-1:0] reg_addr_t;
    typedef logic [DATA_W_DEF-1:0] reg_data_t;

endpackage : reg_file_pkg

// File: rtl/reg_file_sb_scoreboard.sv
// Busy-bit scoreboard: one pending-write flag per register plus a
// registered count of how many registers are currently busy.
// Not affected by REGFILE_BYPASS_EN.
module sb_scoreboard
    import reg_file_pkg::*;
#(
    parameter int unsigned ADDR_W = ADDR_W_DEF,
    parameter int unsigned CNT_W  = ADDR_W + 1
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      iss_valid,
    input  logic [ADDR_W-1:0]         iss_reg,
    input  logic                      regwrite,
    input  logic [ADDR_W-1:0]         wr,
    output logic [(2**ADDR_W)-1:0]    busy,
    output logic [CNT_W-1:0]          pending_cnt
);

    localparam int unsigned NUM_REGS = 2 ** ADDR_W;

    logic [NUM_REGS-1:0] busy_q;
    logic [NUM_REGS-1:0] busy_d;
    logic [CNT_W-1:0]    cnt_q;
    logic [CNT_W-1:0]    cnt_d;

    // Next busy vector: issue beats writeback; register 0 never busy.
    // The count is the popcount of the next vector, so it always tracks it.
    always_comb begin
        busy_d = busy_q;
        cnt_d  = '0;
        busy_d[ZERO_REG] = 1'b0;
        for (int unsigned r = 1; r < NUM_REGS; r++) begin
            if (iss_valid && (iss_reg == ADDR_W'(r))) begin
                busy_d[r] = 1'b1;
            end else if (regwrite && (wr == ADDR_W'(r))) begin
                busy_d[r] = 1'b0;
            end
        end
        for (int unsigned r = 0; r < NUM_REGS; r++) begin
            cnt_d = cnt_d + CNT_W'(busy_d[r]);
        end
    end

    // Busy flags and outstanding-write count state.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            busy_q <= '0;
            cnt_q  <= '0;
        end else begin
            busy_q <= busy_d;
            cnt_q  <= cnt_d;
        end
    end

    assign busy        = busy_q;
    assign pending_cnt = cnt_q;

endmodule : sb_scoreboard

// File: rtl/reg_file_sb.sv
// Parametrised register file with two combinational read ports, one
// synchronous write port and a busy-bit scoreboard for stall detection.
// Define REGFILE_BYPASS_EN to forward writeback data (and clear the busy
// indication) on a same-cycle read of the register being written.
module reg_file_sb
    import reg_file_pkg::*;
#(
    parameter int unsigned DATA_W = DATA_W_DEF,
    parameter int unsigned ADDR_W = ADDR_W_DEF,
    parameter int unsigned CNT_W  = ADDR_W + 1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [ADDR_W-1:0] rr1,
    input  logic [ADDR_W-1:0] rr2,
    output logic [DATA_W-1:0] rd1,
    output logic [DATA_W-1:0] rd2,
    input  logic [ADDR_W-1:0] wr,
    input  logic [DATA_W-1:0] wd,
    input  logic              regwrite,
    input  logic              iss_valid,
    input  logic [ADDR_W-1:0] iss_reg,
    output logic              busy1,
    output logic              busy2,
    output logic              stall,
    output logic [CNT_W-1:0]  pending_cnt
);

    localparam int unsigned       NUM_REGS  = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0] ZERO_ADDR = ADDR_W'(ZERO_REG);

    logic [DATA_W-1:0]   regs_q [NUM_REGS];
    logic [NUM_REGS-1:0] busy_vec;
    logic                wr_en;

    assign wr_en = regwrite && (wr != ZERO_ADDR);

    sb_scoreboard #(
        .ADDR_W (ADDR_W),
        .CNT_W  (CNT_W)
    ) u_sb (
        .clock       (clock),
        .reset       (reset),
        .iss_valid   (iss_valid),
        .iss_reg     (iss_reg),
        .regwrite    (regwrite),
        .wr          (wr),
        .busy        (busy_vec),
        .pending_cnt (pending_cnt)
    );

    // Register storage: asynchronous clear, writes to register 0 dropped.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int unsigned i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= '0;
            end
        end else if (wr_en) begin
            regs_q[wr] <= wd;
        end
    end

    // Read port 1: stored data and busy flag, optional write-through.
    always_comb begin
        rd1   = regs_q[rr1];
        busy1 = busy_vec[rr1];
        if (rr1 == ZERO_ADDR) begin
            rd1   = '0;
            busy1 = 1'b0;
        end
`ifdef REGFILE_BYPASS_EN
        else if (wr_en && (wr == rr1)) begin
            rd1   = wd;
            busy1 = 1'b0;
        end
`endif
    end

    // Read port 2: stored data and busy flag, optional write-through.
    always_comb begin
        rd2   = regs_q[rr2];
        busy2 = busy_vec[rr2];
        if (rr2 == ZERO_ADDR) begin
            rd2   = '0;
            busy2 = 1'b0;
        end
`ifdef REGFILE_BYPASS_EN
        else if (wr_en && (wr == rr2)) begin
            rd2   = wd;
            busy2 = 1'b0;
        end
`endif
    end

    assign stall = busy1 | busy2;

endmodule : reg_file_sb

// File: tb/tb_reg_file_sb.sv
module tb_reg_file_sb;
    import reg_file_pkg::*;

    logic        clock;
    logic        reset;
    logic [2:0]  rr1, rr2, wr, iss_reg;
    logic [15:0] rd1, rd2, wd;
    logic        regwrite, iss_valid;
    logic        busy1, busy2, stall;
    logic [3:0]  pending_cnt;

    int checks = 0;
    int errors = 0;

    // Reference model state
    logic [15:0] m_regs [8];
    bit          m_busy [8];

    reg_file_sb #(.DATA_W(16), .ADDR_W(3), .CNT_W(4)) dut (
        .clock(clock), .reset(reset),
        .rr1(rr1), .rr2(rr2), .rd1(rd1), .rd2(rd2),
        .wr(wr), .wd(wd), .regwrite(regwrite),
        .iss_valid(iss_valid), .iss_reg(iss_reg),
        .busy1(busy1), .busy2(busy2), .stall(stall),
        .pending_cnt(pending_cnt)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    function automatic void model_clear();
        for (int i = 0; i < 8; i++) begin
            m_regs[i] = '0;
            m_busy[i] = 1'b0;
        end
    endfunction

    function automatic logic [15:0] exp_rd(input logic [2:0] a);
        if (a == 3'd0) return '0;
`ifdef REGFILE_BYPASS_EN
        if (regwrite && wr == a) return wd;
`endif
        return m_regs[a];
    endfunction

    function automatic logic exp_busy(input logic [2:0] a);
        if (a == 3'd0) return 1'b0;
`ifdef REGFILE_BYPASS_EN
        if (regwrite && wr == a) return 1'b0;
`endif
        return m_busy[a];
    endfunction

    function automatic logic [3:0] exp_cnt();
        int n = 0;
        for (int i = 0; i < 8; i++) n += int'(m_busy[i]);
        return 4'(n);
    endfunction

    // Advance one clock: apply the architectural rules to the model.
    task automatic tick();
        @(posedge clock);
        if (regwrite && wr != 3'd0) begin
            m_regs[wr] = wd;
            m_busy[wr] = 1'b0;
        end
        if (iss_valid && iss_reg != 3'd0) m_busy[iss_reg] = 1'b1;
        #1;
    endtask

    task automatic idle();
        regwrite  = 1'b0;
        iss_valid = 1'b0;
    endtask

    task automatic do_write(input logic [2:0] a, input logic [15:0] d);
        regwrite = 1'b1; wr = a; wd = d; iss_valid = 1'b0;
        tick();
        idle();
    endtask

    task automatic do_issue(input logic [2:0] a);
        iss_valid = 1'b1; iss_reg = a; regwrite = 1'b0;
        tick();
        idle();
    endtask

    task automatic test_reset();
        #2;
        for (int i = 0; i < 8; i++) begin
            rr1 = 3'(i); rr2 = 3'(7 - i);
            #1;
            checks++;
            if (rd1 !== 16'h0 || rd2 !== 16'h0 || busy1 !== 1'b0 || busy2 !== 1'b0
                || stall !== 1'b0 || pending_cnt !== 4'd0) begin
                errors++;
                $display("FAIL reset_read addr=%0d: rd1=%h rd2=%h b1=%b b2=%b st=%b cnt=%0d, want all 0",
                         i, rd1, rd2, busy1, busy2, stall, pending_cnt);
            end
        end
        @(negedge clock) reset = 1'b0;
        @(posedge clock); #1;
        do_write(3'd3, 16'h00FF);
        rr1 = 3'd3;
        #1;
        checks++;
        if (rd1 !== 16'h00FF) begin
            errors++;
            $display("FAIL pre_reset_r3: rd1=%h want 00ff", rd1);
        end
        reset = 1'b1;
        #1;
        checks++;
        if (rd1 !== 16'h0 || pending_cnt !== 4'd0) begin
            errors++;
            $display("FAIL async_reset_r3: rd1=%h cnt=%0d want 0 0", rd1, pending_cnt);
        end
        model_clear();
        #1 reset = 1'b0;
    endtask

    task automatic test_read_write();
        do_write(3'd1, 16'd15);
        do_write(3'd2, 16'd7);
        rr1 = 3'd1; rr2 = 3'd2;
        #1;
        checks++;
        if (rd1 !== 16'd15 || rd2 !== 16'd7) begin
            errors++;
            $display("FAIL rw_r1_r2: rd1=%0d rd2=%0d want 15 7", rd1, rd2);
        end
        do_write(3'd0, 16'hBEEF);
        rr1 = 3'd0;
        #1;
        checks++;
        if (rd1 !== 16'h0 || busy1 !== 1'b0) begin
            errors++;
            $display("FAIL r0_write_discard: rd1=%h busy1=%b want 0 0", rd1, busy1);
        end
    endtask

    task automatic test_scoreboard();
        do_issue(3'd5);
        rr1 = 3'd5; rr2 = 3'd0;
        #1;
        checks++;
        if (busy1 !== 1'b1 || stall !== 1'b1 || pending_cnt !== 4'd1) begin
            errors++;
            $display("FAIL issue_r5: busy1=%b stall=%b cnt=%0d want 1 1 1", busy1, stall, pending_cnt);
        end
        do_write(3'd5, 16'd22);
        #1;
        checks++;
        if (busy1 !== 1'b0 || rd1 !== 16'd22 || pending_cnt !== 4'd0 || stall !== 1'b0) begin
            errors++;
            $display("FAIL wb_r5: busy1=%b rd1=%0d cnt=%0d stall=%b want 0 22 0 0",
                     busy1, rd1, pending_cnt, stall);
        end
    endtask

    task automatic test_same_cycle();
        do_issue(3'd4);
        iss_valid = 1'b1; iss_reg = 3'd4;
        regwrite = 1'b1; wr = 3'd4; wd = 16'h1234;
        tick();
        idle();
        rr1 = 3'd4;
        #1;
        checks++;
        if (busy1 !== 1'b1 || pending_cnt !== 4'd1 || rd1 !== 16'h1234) begin
            errors++;
            $display("FAIL issue_wb_same: busy1=%b cnt=%0d rd1=%h want 1 1 1234", busy1, pending_cnt, rd1);
        end
        do_write(3'd4, 16'h0);
        do_issue(3'd0);
        rr1 = 3'd0;
        #1;
        checks++;
        if (pending_cnt !== 4'd0 || busy1 !== 1'b0) begin
            errors++;
            $display("FAIL issue_r0: cnt=%0d busy1=%b want 0 0", pending_cnt, busy1);
        end
    endtask

    task automatic test_sequence();
        logic [3:0] want [4] = '{4'd1, 4'd2, 4'd3, 4'd3};
        for (int k = 0; k < 3; k++) begin
            do_issue(3'(k + 1));
            checks++;
            if (pending_cnt !== want[k]) begin
                errors++;
                $display("FAIL seq_cnt step%0d: cnt=%0d want %0d", k, pending_cnt, want[k]);
            end
        end
        regwrite = 1'b1; wr = 3'd2; wd = 16'h0A0A;
        iss_valid = 1'b1; iss_reg = 3'd6;
        tick();
        idle();
        checks++;
        if (pending_cnt !== want[3]) begin
            errors++;
            $display("FAIL seq_cnt step3: cnt=%0d want %0d", pending_cnt, want[3]);
        end
        for (int i = 0; i < 8; i++) begin
            logic w;
            w = (i == 1 || i == 3 || i == 6);
            rr1 = 3'(i);
            #1;
            checks++;
            if (busy1 !== w) begin
                errors++;
                $display("FAIL seq_busy r%0d: busy1=%b want %b", i, busy1, w);
            end
        end
    endtask

    task automatic test_bypass();
        // r3 is 0 and busy from the previous scenario
        regwrite = 1'b1; wr = 3'd3; wd = 16'd8; rr1 = 3'd3;
        #1;
        checks++;
`ifdef REGFILE_BYPASS_EN
        if (rd1 !== 16'd8 || busy1 !== 1'b0) begin
            errors++;
            $display("FAIL bypass_same_cycle: rd1=%0d busy1=%b want 8 0", rd1, busy1);
        end
`else
        if (rd1 !== 16'd0 || busy1 !== 1'b1) begin
            errors++;
            $display("FAIL nobypass_same_cycle: rd1=%0d busy1=%b want 0 1", rd1, busy1);
        end
`endif
        tick();
        idle();
        #1;
        checks++;
        if (rd1 !== 16'd8 || busy1 !== 1'b0) begin
            errors++;
            $display("FAIL bypass_next_cycle: rd1=%0d busy1=%b want 8 0", rd1, busy1);
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 300; n++) begin
            rr1       = 3'($urandom_range(0, 7));
            rr2       = 3'($urandom_range(0, 7));
            wr        = 3'($urandom_range(0, 7));
            wd        = 16'($urandom);
            regwrite  = ($urandom_range(0, 2) != 0);
            iss_valid = ($urandom_range(0, 1) != 0);
            iss_reg   = 3'($urandom_range(0, 7));
            #1;
            checks++;
            if (rd1 !== exp_rd(rr1) || rd2 !== exp_rd(rr2) || busy1 !== exp_busy(rr1)
                || busy2 !== exp_busy(rr2) || stall !== (exp_busy(rr1) | exp_busy(rr2))
                || pending_cnt !== exp_cnt()) begin
                errors++;
                $display("FAIL random cyc%0d: rd1=%h/%h rd2=%h/%h b1=%b/%b b2=%b/%b st=%b cnt=%0d/%0d",
                         n, rd1, exp_rd(rr1), rd2, exp_rd(rr2), busy1, exp_busy(rr1),
                         busy2, exp_busy(rr2), stall, pending_cnt, exp_cnt());
            end
            tick();
        end
        idle();
    endtask

    initial begin
        reset = 1'b1;
        rr1 = '0; rr2 = '0; wr = '0; wd = '0; iss_reg = '0;
        regwrite = 1'b0; iss_valid = 1'b0;
        model_clear();
        test_reset();
        test_read_write();
        test_scoreboard();
        test_same_cycle();
        test_sequence();
        test_bypass();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_reg_file_sb
